// File: rtl/pd_seq_pkg.sv
// Shared types for the power-domain sequencer: internal FSM states, the
// 3-bit state code driven on pd_state, and a counter-width helper.
package pd_seq_pkg;

  typedef enum logic [3:0] {
    ST_RUN,
    ST_ISO_ON,
    ST_SAVE,
    ST_PSW_OFF,
    ST_OFF,
    ST_PSW_ON,
    ST_RESTORE,
    ST_ISO_OFF,
    ST_ERR
  } state_e;

  // Nine states share eight codes: SAVE and RESTORE both report PD_RETN and
  // are told apart by the save/restore pulses themselves.
  typedef enum logic [2:0] {
    PD_RUN     = 3'd0,
    PD_ISO_ON  = 3'd1,
    PD_RETN    = 3'd2,
    PD_PSW_OFF = 3'd3,
    PD_OFF     = 3'd4,
    PD_PSW_ON  = 3'd5,
    PD_ISO_OFF = 3'd6,
    PD_ERR     = 3'd7
  } pd_code_e;

  // Bits needed to count 0..v-1; never less than one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r == 0) ? 1 : r;
  endfunction

  function automatic pd_code_e pd_code(input state_e s);
    case (s)
      ST_RUN:     return PD_RUN;
      ST_ISO_ON:  return PD_ISO_ON;
      ST_SAVE:    return PD_RETN;
      ST_PSW_OFF: return PD_PSW_OFF;
      ST_OFF:     return PD_OFF;
      ST_PSW_ON:  return PD_PSW_ON;
      ST_RESTORE: return PD_RETN;
      ST_ISO_OFF: return PD_ISO_OFF;
      ST_ERR:     return PD_ERR;
      default:    return PD_OFF;
    endcase
  endfunction

endpackage

// File: rtl/iso_clamp_lane.sv
// One isolation lane: registers either the shutdown-domain data or the clamp
// value toward the always-on side.
module iso_clamp_lane #(
  parameter int              SIZE      = 4,
  parameter logic [SIZE-1:0] CLAMP_VAL = '0
) (
  input  logic            clock_i,
  input  logic            rst_ni,
  input  logic            iso_i,
  input  logic [SIZE-1:0] d_i,
  output logic [SIZE-1:0] y_o
);

  logic [SIZE-1:0] y_q;
  logic [SIZE-1:0] y_d;

  assign y_d = iso_i ? CLAMP_VAL : d_i;

  always_ff @(posedge clock_i or negedge rst_ni) begin
    if (!rst_ni) y_q <= CLAMP_VAL;
    else         y_q <= y_d;
  end

  assign y_o = y_q;

endmodule

// File: rtl/pd_iso_sequencer.sv
// Power-down/up sequencer for one switchable domain: staggered isolation,
// retention pulses, power-switch handshake with timeout, clamped output lanes.
module pd_iso_sequencer
  import pd_seq_pkg::*;
#(
  parameter int              SIZE        = 4,
  parameter int              NUM_CH      = 4,
  parameter int              ISO_STEP    = 2,
  parameter int              PSW_TIMEOUT = 255,
  parameter logic [SIZE-1:0] CLAMP_VAL   = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pwr_down_req,
  input  logic                   err_clr,
  input  logic                   psw_ack,
  input  logic [NUM_CH*SIZE-1:0] sh_data,
  output logic [NUM_CH*SIZE-1:0] y,
  output logic [NUM_CH-1:0]      iso_en,
  output logic                   psw_en,
  output logic                   save,
  output logic                   restore,
  output logic                   busy,
  output logic                   err,
  output logic [2:0]             pd_state
);

  localparam int STEP_LAST = (NUM_CH - 1) * ISO_STEP;
  localparam int STEP_W    = clog2(STEP_LAST + 1);
  localparam int TMO_W     = clog2(PSW_TIMEOUT + 1);

  localparam logic [STEP_W-1:0] STEP_END = STEP_W'(STEP_LAST);
  localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(PSW_TIMEOUT);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(PSW_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   iso_en_q, iso_en_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d, tmo_inc;
  logic                psw_en_q, save_q, restore_q, busy_q, err_q;
  pd_code_e            pd_state_q;

  assign tmo_inc = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    iso_en_d = iso_en_q;
    step_d   = '0;
    tmo_d    = '0;
    case (state_q)
      ST_RUN: begin
        iso_en_d = '0;
        if (pwr_down_req) begin
          state_d     = ST_ISO_ON;
          iso_en_d[0] = 1'b1;
        end
      end
      ST_ISO_ON: begin
        step_d = step_q + 1'b1;
        for (int k = 0; k < NUM_CH; k++)
          if (int'(step_q) + 1 == k * ISO_STEP) iso_en_d[k] = 1'b1;
        if (step_q == STEP_END) state_d = ST_SAVE;
      end
      ST_SAVE: state_d = ST_PSW_OFF;
      ST_PSW_OFF: begin
        tmo_d = tmo_inc;
        if (!psw_ack)              state_d = ST_OFF;
        else if (tmo_q == TMO_LAST) state_d = ST_ERR;
      end
      ST_OFF: begin
        iso_en_d = '1;
        if (!pwr_down_req) state_d = ST_PSW_ON;
      end
      ST_PSW_ON: begin
        tmo_d = tmo_inc;
        if (psw_ack)               state_d = ST_RESTORE;
        else if (tmo_q == TMO_LAST) state_d = ST_ERR;
      end
      ST_RESTORE: begin
        state_d              = ST_ISO_OFF;
        iso_en_d[NUM_CH-1]   = 1'b0;
      end
      ST_ISO_OFF: begin
        step_d = step_q + 1'b1;
        for (int k = 0; k < NUM_CH; k++)
          if (int'(step_q) + 1 == (NUM_CH - 1 - k) * ISO_STEP) iso_en_d[k] = 1'b0;
        if (step_q == STEP_END) state_d = ST_RUN;
      end
      ST_ERR: begin
        iso_en_d = '1;
        if (err_clr) state_d = ST_OFF;
      end
      default: begin
        state_d  = ST_OFF;
        iso_en_d = '1;
      end
    endcase
    // Both counters restart from zero in whichever state comes next.
    if (state_d != state_q) begin
      step_d = '0;
      tmo_d  = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_OFF;
      iso_en_q   <= '1;
      step_q     <= '0;
      tmo_q      <= '0;
      psw_en_q   <= 1'b0;
      save_q     <= 1'b0;
      restore_q  <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      pd_state_q <= PD_OFF;
    end else begin
      state_q    <= state_d;
      iso_en_q   <= iso_en_d;
      step_q     <= step_d;
      tmo_q      <= tmo_d;
      psw_en_q   <= !(state_d inside {ST_PSW_OFF, ST_OFF, ST_ERR});
      save_q     <= (state_d == ST_SAVE);
      restore_q  <= (state_d == ST_RESTORE);
      busy_q     <= !(state_d inside {ST_RUN, ST_OFF, ST_ERR});
      err_q      <= (state_d == ST_ERR);
      pd_state_q <= pd_code(state_d);
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
    iso_clamp_lane #(
      .SIZE      (SIZE),
      .CLAMP_VAL (CLAMP_VAL)
    ) u_lane (
      .clock_i (clock),
      .rst_ni  (reset),
      .iso_i   (iso_en_q[gi]),
      .d_i     (sh_data[gi*SIZE +: SIZE]),
      .y_o     (y[gi*SIZE +: SIZE])
    );
  end

  assign iso_en   = iso_en_q;
  assign psw_en   = psw_en_q;
  assign save     = save_q;
  assign restore  = restore_q;
  assign busy     = busy_q;
  assign err      = err_q;
  assign pd_state = pd_state_q;

endmodule

// File: tb/tb_pd_iso_sequencer.sv
// Directed bench for pd_iso_sequencer: power-up/down sequences, timeout,
// mid-sequence request change, async reset and early acknowledge.
module tb_pd_iso_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        pwr_down_req;
  logic        err_clr;
  logic        psw_ack;
  logic [15:0] sh_data;
  logic [15:0] y;
  logic [3:0]  iso_en;
  logic        psw_en, save, restore, busy, err;
  logic [2:0]  pd_state;

  int n_cmp = 0;
  int n_bad = 0;

  // Power-switch model: ack follows psw_en two cycles late unless forced.
  logic [1:0] ack_pipe = 2'b00;
  logic       ack_force = 1'b0;
  logic       ack_force_val = 1'b0;
  always @(posedge clock) ack_pipe <= {ack_pipe[0], psw_en};
  assign psw_ack = ack_force ? ack_force_val : ack_pipe[1];

  always #5 clock = ~clock;

  pd_iso_sequencer #(
    .SIZE        (4),
    .NUM_CH      (4),
    .ISO_STEP    (2),
    .PSW_TIMEOUT (8),
    .CLAMP_VAL   (4'h0)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .pwr_down_req (pwr_down_req),
    .err_clr      (err_clr),
    .psw_ack      (psw_ack),
    .sh_data      (sh_data),
    .y            (y),
    .iso_en       (iso_en),
    .psw_en       (psw_en),
    .save         (save),
    .restore      (restore),
    .busy         (busy),
    .err          (err),
    .pd_state     (pd_state)
  );

  task automatic wait_state(input logic [2:0] code, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (pd_state == code) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; pwr_down_req = 1'b0; err_clr = 1'b0; sh_data = 16'hA5C3;
    repeat (2) @(negedge clock);
    n_cmp++;
    if ({pd_state, iso_en, psw_en, save, restore, busy, err} !== {3'd4, 4'hF, 5'b00000}) begin
      n_bad++;
      $display("FAIL reset_ctrl got st=%0d iso=%b pe/sv/rs/bz/er=%b%b%b%b%b want st=4 iso=1111 00000",
               pd_state, iso_en, psw_en, save, restore, busy, err);
    end
    n_cmp++;
    if (y !== 16'h0000) begin n_bad++; $display("FAIL reset_y got %h want 0000", y); end
    $display("reset: st=%0d iso=%b y=%h", pd_state, iso_en, y);
  endtask

  task automatic test_power_up();
    logic [3:0]  exp_iso [0:6];
    logic [15:0] exp_y   [0:6];
    bit found;
    exp_iso = '{4'b0111, 4'b0111, 4'b0011, 4'b0011, 4'b0001, 4'b0001, 4'b0000};
    exp_y   = '{16'h0000, 16'hA000, 16'hA000, 16'hA500, 16'hA500, 16'hA5C0, 16'hA5C0};
    reset = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (restore) begin found = 1'b1; break; end
    end
    n_cmp++;
    if (!found || pd_state !== 3'd2) begin
      n_bad++; $display("FAIL up_restore found=%0d st=%0d want restore in st=2", found, pd_state);
    end
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      n_cmp++;
      if (pd_state !== 3'd6 || iso_en !== exp_iso[i] || y !== exp_y[i] || restore !== 1'b0) begin
        n_bad++;
        $display("FAIL up_step%0d got st=%0d iso=%b y=%h rs=%b want st=6 iso=%b y=%h rs=0",
                 i, pd_state, iso_en, y, restore, exp_iso[i], exp_y[i]);
      end
      $display("up step %0d: st=%0d iso=%b y=%h", i, pd_state, iso_en, y);
    end
    @(negedge clock);
    n_cmp++;
    if (pd_state !== 3'd0 || y !== 16'hA5C3 || busy !== 1'b0 || psw_en !== 1'b1) begin
      n_bad++;
      $display("FAIL up_run got st=%0d y=%h bz=%b pe=%b want st=0 y=a5c3 bz=0 pe=1", pd_state, y, busy, psw_en);
    end
  endtask

  task automatic test_power_down();
    logic [3:0]  exp_iso [0:6];
    logic [15:0] exp_y   [0:6];
    bit ok;
    exp_iso = '{4'b0001, 4'b0001, 4'b0011, 4'b0011, 4'b0111, 4'b0111, 4'b1111};
    exp_y   = '{16'hA5C3, 16'hA5C0, 16'hA5C0, 16'hA500, 16'hA500, 16'hA000, 16'hA000};
    pwr_down_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      n_cmp++;
      if (pd_state !== 3'd1 || iso_en !== exp_iso[i] || y !== exp_y[i] || save !== 1'b0) begin
        n_bad++;
        $display("FAIL dn_step%0d got st=%0d iso=%b y=%h sv=%b want st=1 iso=%b y=%h sv=0",
                 i, pd_state, iso_en, y, save, exp_iso[i], exp_y[i]);
      end
      $display("down step %0d: st=%0d iso=%b y=%h", i, pd_state, iso_en, y);
    end
    @(negedge clock);
    n_cmp++;
    if (save !== 1'b1 || pd_state !== 3'd2 || y !== 16'h0000 || psw_en !== 1'b1) begin
      n_bad++; $display("FAIL dn_save got sv=%b st=%0d y=%h pe=%b want 1 2 0000 1", save, pd_state, y, psw_en);
    end
    @(negedge clock);
    n_cmp++;
    if (save !== 1'b0 || pd_state !== 3'd3 || psw_en !== 1'b0) begin
      n_bad++; $display("FAIL dn_pswoff got sv=%b st=%0d pe=%b want 0 3 0", save, pd_state, psw_en);
    end
    wait_state(3'd4, 10, ok);
    n_cmp++;
    if (!ok || busy !== 1'b0 || iso_en !== 4'hF) begin
      n_bad++; $display("FAIL dn_off reached=%0d bz=%b iso=%b want 1 0 1111", ok, busy, iso_en);
    end
    $display("down done: st=%0d pe=%b", pd_state, psw_en);
  endtask

  task automatic test_psw_timeout();
    bit ok;
    pwr_down_req = 1'b0;
    wait_state(3'd0, 40, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL tmo_prep_run st=%0d want 0", pd_state); end
    ack_force = 1'b1; ack_force_val = 1'b1;
    pwr_down_req = 1'b1;
    wait_state(3'd3, 20, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL tmo_pswoff st=%0d want 3", pd_state); end
    for (int i = 1; i < 8; i++) begin
      @(negedge clock);
      n_cmp++;
      if (pd_state !== 3'd3) begin n_bad++; $display("FAIL tmo_wait%0d st=%0d want 3", i, pd_state); end
    end
    @(negedge clock);
    n_cmp++;
    if (pd_state !== 3'd7 || err !== 1'b1 || iso_en !== 4'hF || psw_en !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_err got st=%0d er=%b iso=%b pe=%b bz=%b want 7 1 1111 0 0", pd_state, err, iso_en, psw_en, busy);
    end
    $display("timeout: st=%0d err=%b", pd_state, err);
    @(negedge clock);
    n_cmp++;
    if (pd_state !== 3'd7) begin n_bad++; $display("FAIL tmo_hold st=%0d want 7", pd_state); end
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
    n_cmp++;
    if (pd_state !== 3'd4 || err !== 1'b0) begin
      n_bad++; $display("FAIL tmo_clr got st=%0d er=%b want 4 0", pd_state, err);
    end
    ack_force = 1'b0;
  endtask

  task automatic test_req_glitch();
    bit ok;
    bit saw_off, reached;
    int save_cnt, restore_cnt;
    pwr_down_req = 1'b0;
    wait_state(3'd0, 40, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL gl_prep_run st=%0d want 0", pd_state); end
    pwr_down_req = 1'b1;
    wait_state(3'd1, 5, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL gl_isoon st=%0d want 1", pd_state); end
    repeat (2) @(negedge clock);
    pwr_down_req = 1'b0;
    saw_off = 1'b0; reached = 1'b0; save_cnt = 0; restore_cnt = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      if (save) save_cnt++;
      if (restore) restore_cnt++;
      if (pd_state == 3'd4) saw_off = 1'b1;
      if (pd_state == 3'd0 && saw_off) begin reached = 1'b1; break; end
    end
    n_cmp++;
    if (!saw_off || !reached || save_cnt != 1 || restore_cnt != 1) begin
      n_bad++;
      $display("FAIL glitch off=%0d run=%0d saves=%0d restores=%0d want 1 1 1 1", saw_off, reached, save_cnt, restore_cnt);
    end
    $display("glitch: off=%0d run=%0d saves=%0d restores=%0d", saw_off, reached, save_cnt, restore_cnt);
  endtask

  task automatic test_reset_mid();
    bit ok;
    pwr_down_req = 1'b1;
    wait_state(3'd4, 40, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL rm_prep_off st=%0d want 4", pd_state); end
    pwr_down_req = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (pd_state == 3'd6 && iso_en == 4'b0011) begin ok = 1'b1; break; end
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL rm_isooff st=%0d iso=%b want 6 0011", pd_state, iso_en); end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (iso_en !== 4'hF || psw_en !== 1'b0 || y !== 16'h0000 || pd_state !== 3'd4 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rm_async got iso=%b pe=%b y=%h st=%0d bz=%b want 1111 0 0000 4 0", iso_en, psw_en, y, pd_state, busy);
    end
    $display("reset mid: st=%0d iso=%b y=%h", pd_state, iso_en, y);
    @(negedge clock);
    pwr_down_req = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (pd_state !== 3'd4) begin n_bad++; $display("FAIL rm_after st=%0d want 4", pd_state); end
  endtask

  task automatic test_ack_early();
    bit reached;
    ack_force = 1'b1; ack_force_val = 1'b1;
    pwr_down_req = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (pd_state !== 3'd5 || busy !== 1'b1 || psw_en !== 1'b1) begin
      n_bad++; $display("FAIL ea_pswon got st=%0d bz=%b pe=%b want 5 1 1", pd_state, busy, psw_en);
    end
    @(negedge clock);
    n_cmp++;
    if (pd_state !== 3'd2 || restore !== 1'b1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL ea_restore got st=%0d rs=%b bz=%b want 2 1 1", pd_state, restore, busy);
    end
    reached = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (pd_state == 3'd0) begin reached = 1'b1; break; end
      n_cmp++;
      if (busy !== 1'b1) begin n_bad++; $display("FAIL ea_busy%0d got %b want 1 (st=%0d)", i, busy, pd_state); end
    end
    n_cmp++;
    if (!reached || busy !== 1'b0) begin
      n_bad++; $display("FAIL ea_run reached=%0d bz=%b want 1 0", reached, busy);
    end
    $display("ack early: st=%0d bz=%b", pd_state, busy);
    ack_force = 1'b0;
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_power_down();
    test_psw_timeout();
    test_req_glitch();
    test_reset_mid();
    test_ack_early();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/pd_iso_sequencer.md
Name: pd_iso_sequencer

Overview:
Parametrised power-down/power-up sequencer and isolation controller for one switchable (shutdown) domain, feeding an always-on domain through NUM_CH clamped data lanes. It orders isolation, retention save/restore and power-switch control, waits for the power-switch acknowledge with a timeout, and registers the clamped lanes toward the always-on logic. Supplies are handled in UPF; the RTL has no supply ports.

Parameters:
SIZE, 4, width of one data lane
NUM_CH, 4, number of isolation channels/lanes
ISO_STEP, 2, cycles between successive per-channel isolation changes (>=1)
PSW_TIMEOUT, 255, maximum cycles to wait for psw_ack before error (>=1)
CLAMP_VAL, 0, SIZE-bit value driven on an isolated lane

Ports:
clock  in  1  single clock
reset  in  1  asynchronous, active-low reset
pwr_down_req  in  1  level; 1 = domain should be off, 0 = on
err_clr  in  1  one-cycle pulse; leaves ERR
psw_ack  in  1  power-switch status; 1 = domain powered
sh_data  in  NUM_CH*SIZE  lanes from shutdown domain, lane k = bits [k*SIZE +: SIZE]
y  out  NUM_CH*SIZE  registered, clamped lanes
iso_en  out  NUM_CH  per-channel isolation enable, 1 = isolated
psw_en  out  1  power-switch enable, 1 = on
save  out  1  one-cycle retention save pulse
restore  out  1  one-cycle retention restore pulse
busy  out  1  1 in any state except RUN, OFF, ERR
err  out  1  1 in ERR
pd_state  out  3  encoded current state

Behaviour:
- Reset (reset=0, async): state OFF; psw_en=0; iso_en=all 1; save=restore=0; y=CLAMP_VAL on all lanes; err=0; counters 0.
- States: RUN, ISO_ON, SAVE, PSW_OFF, OFF, PSW_ON, RESTORE, ISO_OFF, ERR.
- RUN: psw_en=1, iso_en=0. pwr_down_req=1 -> ISO_ON.
- ISO_ON: channel 0 isolated on entry cycle, channel k isolated k*ISO_STEP cycles later; one cycle after channel NUM_CH-1 is set -> SAVE.
- SAVE: save=1 for exactly this one cycle -> PSW_OFF.
- PSW_OFF: psw_en=0; timeout counter runs from 0; psw_ack=0 -> OFF; counter reaches PSW_TIMEOUT with ack still 1 -> ERR.
- OFF: psw_en=0, iso_en all 1. pwr_down_req=0 -> PSW_ON.
- PSW_ON: psw_en=1; psw_ack=1 -> RESTORE; timeout as above -> ERR.
- RESTORE: restore=1 for exactly one cycle -> ISO_OFF.
- ISO_OFF: release in reverse order, channel NUM_CH-1 on entry, channel k released (NUM_CH-1-k)*ISO_STEP cycles later; one cycle after channel 0 released -> RUN.
- ERR: psw_en=0, iso_en all 1, save=restore=0, err=1; err_clr=1 -> OFF. err_clr is ignored in every other state.
- Request changes mid-sequence are not aborted: the sequence completes to OFF or RUN, then re-evaluates the level. Either stable state may therefore be held for only one cycle.
- psw_ack is sampled only in PSW_OFF/PSW_ON. An ack already at the target value on entry exits after one cycle.
- Data path: y lane k <= iso_en[k] ? CLAMP_VAL : sh_data lane k, registered with 1-cycle latency using the iso_en value of the same cycle. Changes in iso_en therefore appear on y one cycle later.
- Timeout counter width is clog2(PSW_TIMEOUT+1). It saturates and never wraps. It is cleared on every state entry.
- Async reset mid-sequence forces reset values immediately. No pulse may stretch.

Decomposition:
- Package pd_seq_pkg: state enum with the 3-bit encoding used on pd_state, and the clog2 helper for counter widths.
- Sub-module iso_clamp_lane, parameterised by SIZE and CLAMP_VAL, holds one lane's registered clamp. It is instantiated NUM_CH times via generate.
- The FSM, step counter and timeout counter live in the top module.

Test Plan:
1. Defaults SIZE=4, NUM_CH=4, ISO_STEP=2, PSW_TIMEOUT=8, CLAMP_VAL=0. Release reset with req=0 and ack following psw_en after 2 cycles. Required: PSW_ON, then restore pulse, then iso_en steps 1111->0111->0011->0001->0000 two cycles apart, then RUN. With sh_data=16'hA5C3, y=16'hA5C3 one cycle after iso_en=0000.
2. In RUN, req=1. Required: iso_en steps 0001->0011->0111->1111 two cycles apart, lanes of y going to 0 in that order one cycle after each step. Then a 1-cycle save pulse, psw_en=0, and OFF after ack drops.
3. In PSW_OFF, hold ack=1. Required: ERR exactly 8 cycles after entry, err=1, iso_en=1111, psw_en=0. err_clr then gives OFF with err=0.
4. Pulse req 1->0 during ISO_ON. Required: the down sequence completes to OFF, then powers up to RUN. No skipped save/restore pulse.
5. Assert reset during ISO_OFF with iso_en=0011. Required: immediate iso_en=1111, psw_en=0, y=0, pd_state=OFF.
6. ack already 1 on entering PSW_ON. Required: RESTORE on the next cycle, with busy=1 throughout the sequence.
